// File: rtl/pixel_test_sequencer_pkg.sv
// Shared types and register map for the pixel test sequencer.
// Addresses are functions of the channel count so the map scales with NUM_CH.
package pixel_test_sequencer_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   function automatic int a_rise(int k);
      return k;
   endfunction

   function automatic int a_fall(int n, int k);
      return n + k;
   endfunction

   function automatic int a_meas(int n);
      return 2 * n;
   endfunction

   function automatic int a_period(int n);
      return 2 * n + 1;
   endfunction

   function automatic int a_repeat(int n);
      return 2 * n + 2;
   endfunction

   function automatic int a_static(int n);
      return 2 * n + 3;
   endfunction

endpackage

// File: rtl/pixel_test_sequencer_if.sv
// Config register port between the SPI command decoder and the sequencer.
interface pixel_test_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic              cfg_write;
   logic [ADDR_W-1:0] cfg_addr;
   logic [15:0]       cfg_wdata;
   logic [15:0]       cfg_rdata;

   modport master (
      output cfg_write, cfg_addr, cfg_wdata,
      input  cfg_rdata
   );

   modport slave (
      input  cfg_write, cfg_addr, cfg_wdata,
      output cfg_rdata
   );
endinterface

// File: rtl/pixel_test_sequencer_cmp.sv
// One timed channel: shadow rise/fall edges and the registered output bit.
// Compares against next-state t so the output lines up with t exactly.
module seq_channel_cmp #(
   parameter int   TIME_W = 10,
   parameter logic IDLE   = 1'b0
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic              load,
   input  logic [TIME_W-1:0] rise_i,
   input  logic [TIME_W-1:0] fall_i,
   input  logic [TIME_W-1:0] t_nxt,
   input  logic              run_nxt,
   output logic              ch_o
);
   logic [TIME_W-1:0] rise_q, rise_d;
   logic [TIME_W-1:0] fall_q, fall_d;
   logic              ch_q, ch_d;

   always_comb begin
      rise_d = load ? rise_i : rise_q;
      fall_d = load ? fall_i : fall_q;
      ch_d   = IDLE;
      if (run_nxt && t_nxt >= rise_d && t_nxt < fall_d)
         ch_d = ~IDLE;
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         rise_q <= '0;
         fall_q <= '0;
         ch_q   <= IDLE;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
         ch_q   <= ch_d;
      end
   end

   assign ch_o = ch_q;
endmodule

// File: rtl/pixel_test_sequencer.sv
// Pixel test-structure sequencer: config regs, run FSM, period/burst
// counters, measure window and per-channel timed outputs.
module pixel_test_sequencer
   import pixel_test_sequencer_pkg::*;
#(
   parameter int                NUM_CH   = 3,
   parameter int                TIME_W   = 10,
   parameter int                STATIC_W = 7,
   parameter logic [NUM_CH-1:0] CH_IDLE  = '0,
   parameter int                ADDR_W   = 5
) (
   input  logic                clk,
   input  logic                res_n,
   pixel_test_sequencer_if.slave cfg,
   input  logic                start,
   input  logic                abort,
   output logic [NUM_CH-1:0]   ch_out,
   output logic [STATIC_W-1:0] static_out,
   output logic                ready,
   output logic                measure,
   output logic                run_done,
   output logic                aborted,
   output logic [15:0]         runs_left
);
   logic [TIME_W-1:0]   rise_q [NUM_CH];
   logic [TIME_W-1:0]   rise_d [NUM_CH];
   logic [TIME_W-1:0]   fall_q [NUM_CH];
   logic [TIME_W-1:0]   fall_d [NUM_CH];
   logic [TIME_W-1:0]   meas_q, meas_d;
   logic [TIME_W-1:0]   per_q, per_d;
   logic [15:0]         rep_q, rep_d;
   logic [STATIC_W-1:0] stat_q, stat_d;
   logic [TIME_W-1:0]   meas_sh_q, meas_sh_d;
   logic [TIME_W-1:0]   per_sh_q, per_sh_d;
   state_e              state_q, state_d;
   logic [TIME_W-1:0]   t_q, t_d;
   logic [15:0]         runs_q, runs_d;
   logic [STATIC_W-1:0] sout_q, sout_d;
   logic                meas_out_q, meas_out_d;
   logic                done_q, done_d;
   logic                abrt_q, abrt_d;
   logic [31:0]         addr_w;
   logic [TIME_W-1:0]   p_eff;
   logic                go, last_t, run_nxt;

   assign addr_w = 32'(cfg.cfg_addr);

   always_comb begin : reg_write
      rise_d = rise_q;
      fall_d = fall_q;
      meas_d = meas_q;
      per_d  = per_q;
      rep_d  = rep_q;
      stat_d = stat_q;
      if (cfg.cfg_write) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (addr_w == a_rise(k))
               rise_d[k] = cfg.cfg_wdata[TIME_W-1:0];
            if (addr_w == a_fall(NUM_CH, k))
               fall_d[k] = cfg.cfg_wdata[TIME_W-1:0];
         end
         if (addr_w == a_meas(NUM_CH))
            meas_d = cfg.cfg_wdata[TIME_W-1:0];
         if (addr_w == a_period(NUM_CH))
            per_d = cfg.cfg_wdata[TIME_W-1:0];
         if (addr_w == a_repeat(NUM_CH))
            rep_d = cfg.cfg_wdata;
         if (addr_w == a_static(NUM_CH))
            stat_d = cfg.cfg_wdata[STATIC_W-1:0];
      end
   end

   always_comb begin : reg_read
      cfg.cfg_rdata = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (addr_w == a_rise(k))
            cfg.cfg_rdata = 16'(rise_q[k]);
         if (addr_w == a_fall(NUM_CH, k))
            cfg.cfg_rdata = 16'(fall_q[k]);
      end
      if (addr_w == a_meas(NUM_CH))
         cfg.cfg_rdata = 16'(meas_q);
      if (addr_w == a_period(NUM_CH))
         cfg.cfg_rdata = 16'(per_q);
      if (addr_w == a_repeat(NUM_CH))
         cfg.cfg_rdata = rep_q;
      if (addr_w == a_static(NUM_CH))
         cfg.cfg_rdata = 16'(stat_q);
   end

   // Shadows load the post-write live value, so a same-cycle write wins.
   assign go     = (state_q == S_IDLE) && start && !abort;
   assign p_eff  = (per_sh_q == '0) ? TIME_W'(1) : per_sh_q;
   assign last_t = (t_q == p_eff - TIME_W'(1));

   always_comb begin : fsm
      state_d = state_q;
      t_d     = t_q;
      runs_d  = runs_q;
      done_d  = 1'b0;
      abrt_d  = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
         t_d     = '0;
         runs_d  = '0;
         abrt_d  = (state_q == S_RUN);
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_RUN;
                  t_d     = '0;
                  runs_d  = (rep_d == '0) ? 16'd1 : rep_d;
               end
            end
            S_RUN: begin
               if (!last_t) begin
                  t_d = t_q + TIME_W'(1);
               end else if (runs_q > 16'd1) begin
                  t_d    = '0;
                  runs_d = runs_q - 16'd1;
               end else begin
                  state_d = S_IDLE;
                  t_d     = '0;
                  runs_d  = '0;
                  done_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin : outs
      run_nxt    = (state_d == S_RUN);
      meas_sh_d  = go ? meas_d : meas_sh_q;
      per_sh_d   = go ? per_d : per_sh_q;
      sout_d     = go ? stat_d : sout_q;
      meas_out_d = run_nxt && (t_d < meas_sh_d);
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            rise_q[k] <= '0;
            fall_q[k] <= '0;
         end
         meas_q     <= '0;
         per_q      <= '0;
         rep_q      <= '0;
         stat_q     <= '0;
         meas_sh_q  <= '0;
         per_sh_q   <= '0;
         state_q    <= S_IDLE;
         t_q        <= '0;
         runs_q     <= '0;
         sout_q     <= '0;
         meas_out_q <= 1'b0;
         done_q     <= 1'b0;
         abrt_q     <= 1'b0;
      end else begin
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         meas_q     <= meas_d;
         per_q      <= per_d;
         rep_q      <= rep_d;
         stat_q     <= stat_d;
         meas_sh_q  <= meas_sh_d;
         per_sh_q   <= per_sh_d;
         state_q    <= state_d;
         t_q        <= t_d;
         runs_q     <= runs_d;
         sout_q     <= sout_d;
         meas_out_q <= meas_out_d;
         done_q     <= done_d;
         abrt_q     <= abrt_d;
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      seq_channel_cmp #(
         .TIME_W (TIME_W),
         .IDLE   (CH_IDLE[k])
      ) u_cmp (
         .clk     (clk),
         .res_n   (res_n),
         .load    (go),
         .rise_i  (rise_d[k]),
         .fall_i  (fall_d[k]),
         .t_nxt   (t_d),
         .run_nxt (run_nxt),
         .ch_o    (ch_out[k])
      );
   end

   assign static_out = sout_q;
   assign ready      = (state_q == S_IDLE);
   assign measure    = meas_out_q;
   assign run_done   = done_q;
   assign aborted    = abrt_q;
   assign runs_left  = runs_q;
endmodule

// File: tb/tb_pixel_test_sequencer.sv
// Directed bench: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the sequencer outputs.
module tb_pixel_test_sequencer;

   typedef struct {
      int          cyc;
      bit          oc;
      logic [2:0]  ch;
      bit          m;
      bit          rdy;
      logic [15:0] rl;
      bit          dn;
      bit          ab;
      logic [6:0]  st;
      bit          rdc;
      logic [15:0] rd;
      string       nm;
   } exp_t;

   logic        clk = 1'b0;
   logic        res_n;
   logic        start;
   logic        abort;
   logic [2:0]  ch_out;
   logic [6:0]  static_out;
   logic        ready;
   logic        measure;
   logic        run_done;
   logic        aborted;
   logic [15:0] runs_left;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   string tname = "T1";
   exp_t  q[$];
   exp_t  me;

   pixel_test_sequencer_if #(.ADDR_W(5)) bus ();

   pixel_test_sequencer #(
      .NUM_CH   (3),
      .TIME_W   (10),
      .STATIC_W (7),
      .CH_IDLE  (3'b100),
      .ADDR_W   (5)
   ) dut (
      .clk        (clk),
      .res_n      (res_n),
      .cfg        (bus.slave),
      .start      (start),
      .abort      (abort),
      .ch_out     (ch_out),
      .static_out (static_out),
      .ready      (ready),
      .measure    (measure),
      .run_done   (run_done),
      .aborted    (aborted),
      .runs_left  (runs_left)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void put(exp_t e);
      int   i;
      exp_t o;
      i = 0;
      while (i < q.size() && q[i].cyc < e.cyc) i++;
      if (i < q.size() && q[i].cyc == e.cyc) begin
         o = q[i];
         if (e.rdc) begin
            o.rdc = 1'b1;
            o.rd  = e.rd;
         end
         if (e.oc) begin
            e.rdc = o.rdc;
            e.rd  = o.rd;
            o     = e;
         end
         q[i] = o;
      end else begin
         q.insert(i, e);
      end
   endfunction

   task automatic po(int c, logic [2:0] ch, bit m, bit rdy,
                     logic [15:0] rl, bit dn, bit ab, logic [6:0] st);
      exp_t e;
      e.cyc = c;   e.oc = 1'b1; e.ch = ch;  e.m = m;
      e.rdy = rdy; e.rl = rl;   e.dn = dn;  e.ab = ab;
      e.st = st;   e.rdc = 1'b0; e.rd = '0; e.nm = tname;
      put(e);
   endtask

   task automatic pr(int c, logic [15:0] rd);
      exp_t e;
      e.cyc = c;   e.oc = 1'b0; e.ch = '0;  e.m = 1'b0;
      e.rdy = 1'b0; e.rl = '0;  e.dn = 1'b0; e.ab = 1'b0;
      e.st = '0;   e.rdc = 1'b1; e.rd = rd; e.nm = tname;
      put(e);
   endtask

   // v0/vm: hand-written ch0 and measure patterns, bit t = value at t.
   task automatic run_exp(int f, int p, int reps, logic [15:0] v0,
                          logic [15:0] vm, logic [6:0] st);
      for (int r = 0; r < reps; r++)
         for (int t = 0; t < p; t++)
            po(f + r * p + t, {2'b11, v0[t]}, vm[t], 1'b0,
               16'(reps - r), 1'b0, 1'b0, st);
      po(f + reps * p, 3'b100, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, st);
      po(f + reps * p + 1, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, st);
   endtask

   task automatic cyc_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c) cyc_step();
   endtask

   task automatic wr(int a, logic [15:0] d);
      bus.cfg_write = 1'b1;
      bus.cfg_addr  = 5'(a);
      bus.cfg_wdata = d;
      cyc_step();
      bus.cfg_write = 1'b0;
   endtask

   task automatic rdchk(int a, logic [15:0] v);
      bus.cfg_addr = 5'(a);
      pr(cyc, v);
      cyc_step();
   endtask

   task automatic go();
      start = 1'b1;
      cyc_step();
      start = 1'b0;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
         me = q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s stale cyc=%0d now=%0d", me.nm, me.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         me = q.pop_front();
         if (me.oc) begin
            n_cmp++;
            if ({ch_out, measure, ready, runs_left, run_done,
                 aborted, static_out} !==
                {me.ch, me.m, me.rdy, me.rl, me.dn, me.ab, me.st}) begin
               n_bad++;
               $display({"FAIL %s out cyc=%0d got ch=%b m=%b rdy=%b",
                         " rl=%0d dn=%b ab=%b st=%h; exp ch=%b m=%b",
                         " rdy=%b rl=%0d dn=%b ab=%b st=%h"},
                        me.nm, cyc, ch_out, measure, ready, runs_left,
                        run_done, aborted, static_out, me.ch, me.m,
                        me.rdy, me.rl, me.dn, me.ab, me.st);
            end
         end
         if (me.rdc) begin
            n_cmp++;
            if (bus.cfg_rdata !== me.rd) begin
               n_bad++;
               $display("FAIL %s rdata cyc=%0d addr=%0d got=%h exp=%h",
                        me.nm, cyc, bus.cfg_addr, bus.cfg_rdata, me.rd);
            end
         end
      end
   end

   initial begin
      int f;
      res_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      bus.cfg_write = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;

      // Reset state
      tname = "RST";
      cyc_step();
      cyc_step();
      po(cyc, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 7'h00);
      pr(cyc, 16'h0000);
      cyc_step();
      res_n = 1'b1;
      cyc_step();
      po(cyc, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 7'h00);
      cyc_step();

      // T2 single run
      tname = "T2";
      wr(0, 16'd2);
      wr(3, 16'd5);
      wr(1, 16'd0);
      wr(4, 16'd8);
      wr(6, 16'd4);
      wr(7, 16'd8);
      wr(8, 16'd0);
      wr(9, 16'h005A);
      rdchk(3, 16'd5);
      f = cyc + 1;
      run_exp(f, 8, 1, 16'h001C, 16'h000F, 7'h5A);
      go();
      wait_cyc(f + 9);

      // T3 burst, start held into RUN is ignored
      tname = "T3";
      wr(7, 16'd4);
      wr(8, 16'd3);
      wr(9, 16'h0033);
      f = cyc + 1;
      run_exp(f, 4, 3, 16'h000C, 16'h000F, 7'h33);
      start = 1'b1;
      cyc_step();
      cyc_step();
      cyc_step();
      start = 1'b0;
      wait_cyc(f + 13);

      // T4 abort at t=3 of run 2, then abort+start in IDLE
      tname = "T4";
      wr(9, 16'h0011);
      f = cyc + 1;
      for (int i = 0; i < 8; i++)
         po(f + i, {2'b11, ((i % 4) >= 2) ? 1'b1 : 1'b0}, 1'b1, 1'b0,
            16'(3 - i / 4), 1'b0, 1'b0, 7'h11);
      po(f + 8, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 7'h11);
      po(f + 9, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 7'h11);
      po(f + 10, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 7'h11);
      go();
      wait_cyc(f + 7);
      abort = 1'b1;
      cyc_step();
      abort = 1'b0;
      cyc_step();
      start = 1'b1;
      abort = 1'b1;
      cyc_step();
      start = 1'b0;
      abort = 1'b0;
      cyc_step();

      // T5 shadowing
      tname = "T5a";
      wr(7, 16'd8);
      wr(8, 16'd0);
      f = cyc + 1;
      run_exp(f, 8, 1, 16'h001C, 16'h000F, 7'h11);
      go();
      wr(3, 16'd7);
      bus.cfg_addr = 5'd3;
      pr(cyc, 16'd7);
      cyc_step();
      wait_cyc(f + 9);
      tname = "T5b";
      f = cyc + 1;
      run_exp(f, 8, 1, 16'h007C, 16'h000F, 7'h11);
      go();
      wait_cyc(f + 9);
      tname = "T5c";
      f = cyc + 1;
      run_exp(f, 8, 1, 16'h0004, 16'h000F, 7'h11);
      bus.cfg_write = 1'b1;
      bus.cfg_addr  = 5'd3;
      bus.cfg_wdata = 16'd3;
      start = 1'b1;
      cyc_step();
      bus.cfg_write = 1'b0;
      start = 1'b0;
      wait_cyc(f + 9);

      // T6 edge cases
      tname = "T6a";
      wr(0, 16'd3);
      wr(3, 16'd3);
      f = cyc + 1;
      run_exp(f, 8, 1, 16'h0000, 16'h000F, 7'h11);
      go();
      wait_cyc(f + 9);
      tname = "T6b";
      wr(7, 16'd0);
      wr(8, 16'd2);
      f = cyc + 1;
      run_exp(f, 1, 2, 16'h0000, 16'h0001, 7'h11);
      go();
      wait_cyc(f + 3);
      tname = "T6c";
      wr(10, 16'hFFFF);
      rdchk(10, 16'h0000);
      rdchk(0, 16'd3);
      rdchk(9, 16'h0011);
      wr(0, 16'hFC05);
      rdchk(0, 16'h0005);
      wr(8, 16'hABCD);
      rdchk(8, 16'hABCD);
      rdchk(7, 16'h0000);

      // T1 async reset mid-run
      tname = "T1";
      wr(7, 16'd8);
      wr(8, 16'd3);
      f = cyc + 1;
      po(f, 3'b110, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 7'h11);
      po(f + 1, 3'b110, 1'b1, 1'b0, 16'd3, 1'b0, 1'b0, 7'h11);
      go();
      wait_cyc(f + 2);
      bus.cfg_addr = 5'd0;
      po(cyc, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 7'h00);
      pr(cyc, 16'h0000);
      #2;
      res_n = 1'b0;
      cyc_step();
      po(cyc, 3'b100, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 7'h00);
      pr(cyc, 16'h0000);
      cyc_step();
      res_n = 1'b1;

      for (int i = 0; i < 20 && q.size() > 0; i++) cyc_step();
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
